// File: rtl/riscv_pkg.sv
// Shared constants and the fetch FSM state encoding for the RV32 pipeline.
package riscv_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    StReq  = 2'd0,
    StWait = 2'd1,
    StHold = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_cycle_if.sv
// Single-outstanding instruction-memory request/response bus.
interface fetch_cycle_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rvalid,
    output imem_rdata
  );

endinterface

// File: rtl/fetch_cycle.sv
// Instruction fetch stage: PC register, imem request FSM, one-entry hold buffer and IF/ID register.
module fetch_cycle #(
  parameter logic [31:0] RESET_PC  = riscv_pkg::RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          StallD,
  input  logic          FlushD,
  input  logic          PCSrcE,
  input  logic [31:0]   PCTargetE,
  fetch_cycle_if.master bus,
  output logic [31:0]   InstrD,
  output logic [31:0]   PCD,
  output logic [31:0]   PCPlus4D
);

  import riscv_pkg::fetch_state_e;
  import riscv_pkg::StReq;
  import riscv_pkg::StWait;
  import riscv_pkg::StHold;

  fetch_state_e state_q, state_d;
  logic         kill_q, kill_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  hold_instr_q, hold_instr_d;
  logic [31:0]  hold_pc_q, hold_pc_d;
  logic [31:0]  ifid_instr_q, ifid_instr_d;
  logic [31:0]  ifid_pc_q, ifid_pc_d;
  logic [31:0]  ifid_pc4_q, ifid_pc4_d;

  logic         handshake, delivery, consumed;
  logic [31:0]  cand_instr, cand_pc, redirect_pc;
  logic         unused_tgt_lsb;

  assign unused_tgt_lsb = ^PCTargetE[1:0];
  assign redirect_pc    = {PCTargetE[31:2], 2'b00};

  assign bus.imem_req  = (state_q == StReq) && !rst;
  assign bus.imem_addr = pc_q;

  assign handshake  = bus.imem_req && bus.imem_ready;
  assign delivery   = ((state_q == StWait) && bus.imem_rvalid && !kill_q) || (state_q == StHold);
  assign consumed   = delivery && !StallD && !FlushD && !PCSrcE;
  assign cand_instr = (state_q == StHold) ? hold_instr_q : bus.imem_rdata;
  assign cand_pc    = (state_q == StHold) ? hold_pc_q : pc_q;

  always_comb begin
    state_d      = state_q;
    kill_d       = kill_q;
    hold_instr_d = hold_instr_q;
    hold_pc_d    = hold_pc_q;

    if (PCSrcE) begin
      pc_d = redirect_pc;
    end else if (consumed) begin
      pc_d = pc_q + 32'd4;
    end else begin
      pc_d = pc_q;
    end

    unique case (state_q)
      StReq: begin
        // A request accepted alongside a redirect carries the stale PC.
        if (handshake) begin
          state_d = StWait;
          kill_d  = PCSrcE;
        end
      end
      StWait: begin
        if (bus.imem_rvalid) begin
          kill_d = 1'b0;
          if (kill_q || PCSrcE || FlushD || !StallD) begin
            state_d = StReq;
          end else begin
            state_d      = StHold;
            hold_instr_d = bus.imem_rdata;
            hold_pc_d    = pc_q;
          end
        end else if (PCSrcE) begin
          kill_d = 1'b1;
        end
      end
      StHold: begin
        if (PCSrcE || FlushD || !StallD) begin
          state_d = StReq;
        end
      end
      default: state_d = StReq;
    endcase
  end

  always_comb begin
    ifid_instr_d = NOP_INSTR;
    ifid_pc_d    = 32'd0;
    ifid_pc4_d   = 32'd0;
    if (FlushD) begin
      ifid_instr_d = NOP_INSTR;
    end else if (StallD) begin
      ifid_instr_d = ifid_instr_q;
      ifid_pc_d    = ifid_pc_q;
      ifid_pc4_d   = ifid_pc4_q;
    end else if (consumed) begin
      ifid_instr_d = cand_instr;
      ifid_pc_d    = cand_pc;
      ifid_pc4_d   = cand_pc + 32'd4;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StReq;
      kill_q       <= 1'b0;
      pc_q         <= RESET_PC;
      hold_instr_q <= 32'd0;
      hold_pc_q    <= 32'd0;
      ifid_instr_q <= NOP_INSTR;
      ifid_pc_q    <= 32'd0;
      ifid_pc4_q   <= 32'd0;
    end else begin
      state_q      <= state_d;
      kill_q       <= kill_d;
      pc_q         <= pc_d;
      hold_instr_q <= hold_instr_d;
      hold_pc_q    <= hold_pc_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_pc4_q   <= ifid_pc4_d;
    end
  end

  assign InstrD   = ifid_instr_q;
  assign PCD      = ifid_pc_q;
  assign PCPlus4D = ifid_pc4_q;

endmodule

// File: tb/tb_fetch_cycle.sv
// Directed bench for fetch_cycle with a variable-latency instruction memory returning addr|0xA000_0000.
module tb_fetch_cycle;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        StallD, FlushD, PCSrcE;
  logic [31:0] PCTargetE;
  logic [31:0] InstrD, PCD, PCPlus4D;

  int total = 0;
  int bad   = 0;

  int          mem_lat = 1;
  logic        pend;
  int          cnt;
  logic [31:0] paddr;

  fetch_cycle_if bus ();

  fetch_cycle dut (
    .clk       (clk),
    .rst       (rst),
    .StallD    (StallD),
    .FlushD    (FlushD),
    .PCSrcE    (PCSrcE),
    .PCTargetE (PCTargetE),
    .bus       (bus),
    .InstrD    (InstrD),
    .PCD       (PCD),
    .PCPlus4D  (PCPlus4D)
  );

  always #5 clk = ~clk;

  // Memory model: response visible mem_lat cycles after acceptance; pending work dropped on reset.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.imem_rvalid <= 1'b0;
      bus.imem_rdata  <= 32'd0;
      pend            <= 1'b0;
      cnt             <= 0;
      paddr           <= 32'd0;
    end else begin
      bus.imem_rvalid <= 1'b0;
      if (pend) begin
        if (cnt <= 1) begin
          bus.imem_rvalid <= 1'b1;
          bus.imem_rdata  <= paddr | 32'hA000_0000;
          pend            <= 1'b0;
        end else begin
          cnt <= cnt - 1;
        end
      end
      if (bus.imem_req && bus.imem_ready) begin
        if (mem_lat <= 1) begin
          bus.imem_rvalid <= 1'b1;
          bus.imem_rdata  <= bus.imem_addr | 32'hA000_0000;
        end else begin
          pend  <= 1'b1;
          cnt   <= mem_lat - 1;
          paddr <= bus.imem_addr;
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    StallD = 1'b0; FlushD = 1'b0; PCSrcE = 1'b0; PCTargetE = 32'd0;
    bus.imem_ready = 1'b1;
    mem_lat = 1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    tick();
    total++; if (InstrD !== 32'h13) begin bad++; $display("FAIL rst_instr got=%h want=%h", InstrD, 32'h13); end
    total++; if (PCD !== 32'd0) begin bad++; $display("FAIL rst_pcd got=%h want=%h", PCD, 32'd0); end
    total++; if (PCPlus4D !== 32'd0) begin bad++; $display("FAIL rst_pc4 got=%h want=%h", PCPlus4D, 32'd0); end
    total++; if (bus.imem_req !== 1'b0) begin bad++; $display("FAIL rst_req got=%b want=0", bus.imem_req); end
    total++; if (bus.imem_addr !== 32'd0) begin bad++; $display("FAIL rst_addr got=%h want=%h", bus.imem_addr, 32'd0); end
    rst = 1'b0;
    #1;
    total++; if (bus.imem_req !== 1'b1) begin bad++; $display("FAIL first_req got=%b want=1", bus.imem_req); end
    total++; if (bus.imem_addr !== 32'd0) begin bad++; $display("FAIL first_addr got=%h want=%h", bus.imem_addr, 32'd0); end
  endtask

  task automatic test_basic();
    logic [31:0] exp_i [4];
    logic [31:0] exp_p [4];
    logic [31:0] exp_4 [4];
    exp_i = '{32'h13, 32'hA000_0000, 32'h13, 32'hA000_0004};
    exp_p = '{32'h0, 32'h0, 32'h0, 32'h4};
    exp_4 = '{32'h0, 32'h4, 32'h0, 32'h8};
    for (int i = 0; i < 4; i++) begin
      tick();
      total++; if (InstrD !== exp_i[i]) begin bad++; $display("FAIL basic_instr[%0d] got=%h want=%h", i, InstrD, exp_i[i]); end
      total++; if (PCD !== exp_p[i]) begin bad++; $display("FAIL basic_pcd[%0d] got=%h want=%h", i, PCD, exp_p[i]); end
      total++; if (PCPlus4D !== exp_4[i]) begin bad++; $display("FAIL basic_pc4[%0d] got=%h want=%h", i, PCPlus4D, exp_4[i]); end
    end
    total++; if (bus.imem_addr !== 32'h8) begin bad++; $display("FAIL basic_addr got=%h want=%h", bus.imem_addr, 32'h8); end
  endtask

  task automatic test_stall();
    StallD = 1'b1;
    tick();
    total++; if (InstrD !== 32'hA000_0004) begin bad++; $display("FAIL stall_instr got=%h want=%h", InstrD, 32'hA000_0004); end
    total++; if (PCD !== 32'h4) begin bad++; $display("FAIL stall_pcd got=%h want=%h", PCD, 32'h4); end
    for (int i = 0; i < 2; i++) begin
      tick();
      total++; if (bus.imem_req !== 1'b0) begin bad++; $display("FAIL hold_req[%0d] got=%b want=0", i, bus.imem_req); end
      total++; if (InstrD !== 32'hA000_0004) begin bad++; $display("FAIL hold_instr[%0d] got=%h want=%h", i, InstrD, 32'hA000_0004); end
    end
    StallD = 1'b0;
    tick();
    total++; if (InstrD !== 32'hA000_0008) begin bad++; $display("FAIL unstall_instr got=%h want=%h", InstrD, 32'hA000_0008); end
    total++; if (PCD !== 32'h8) begin bad++; $display("FAIL unstall_pcd got=%h want=%h", PCD, 32'h8); end
    total++; if (PCPlus4D !== 32'hC) begin bad++; $display("FAIL unstall_pc4 got=%h want=%h", PCPlus4D, 32'hC); end
    total++; if (bus.imem_req !== 1'b1) begin bad++; $display("FAIL unstall_req got=%b want=1", bus.imem_req); end
    total++; if (bus.imem_addr !== 32'hC) begin bad++; $display("FAIL unstall_addr got=%h want=%h", bus.imem_addr, 32'hC); end
  endtask

  task automatic test_flush_redirect();
    mem_lat = 3;
    tick();
    total++; if (InstrD !== 32'h13) begin bad++; $display("FAIL fr_bubble got=%h want=%h", InstrD, 32'h13); end
    PCSrcE = 1'b1; FlushD = 1'b1; PCTargetE = 32'h103;
    tick();
    PCSrcE = 1'b0; FlushD = 1'b0;
    total++; if (InstrD !== 32'h13) begin bad++; $display("FAIL fr_flush_instr got=%h want=%h", InstrD, 32'h13); end
    total++; if (bus.imem_req !== 1'b0) begin bad++; $display("FAIL fr_wait_req got=%b want=0", bus.imem_req); end
    tick();
    mem_lat = 1;
    total++; if (InstrD !== 32'h13) begin bad++; $display("FAIL fr_late_instr got=%h want=%h", InstrD, 32'h13); end
    tick();
    total++; if (InstrD !== 32'h13) begin bad++; $display("FAIL fr_discard_instr got=%h want=%h", InstrD, 32'h13); end
    total++; if (bus.imem_addr !== 32'h100) begin bad++; $display("FAIL fr_addr got=%h want=%h", bus.imem_addr, 32'h100); end
    total++; if (bus.imem_req !== 1'b1) begin bad++; $display("FAIL fr_req got=%b want=1", bus.imem_req); end
    tick();
    tick();
    total++; if (InstrD !== 32'hA000_0100) begin bad++; $display("FAIL fr_instr got=%h want=%h", InstrD, 32'hA000_0100); end
    total++; if (PCD !== 32'h100) begin bad++; $display("FAIL fr_pcd got=%h want=%h", PCD, 32'h100); end
  endtask

  task automatic test_redirect_handshake();
    bus.imem_ready = 1'b0; PCSrcE = 1'b1; PCTargetE = 32'h10;
    tick();
    total++; if (bus.imem_addr !== 32'h10) begin bad++; $display("FAIL rh_noshake_addr got=%h want=%h", bus.imem_addr, 32'h10); end
    total++; if (bus.imem_req !== 1'b1) begin bad++; $display("FAIL rh_noshake_req got=%b want=1", bus.imem_req); end
    bus.imem_ready = 1'b1; PCTargetE = 32'h40;
    tick();
    PCSrcE = 1'b0;
    for (int i = 0; i < 3; i++) begin
      total++; if (InstrD !== 32'h13) begin bad++; $display("FAIL rh_stale_instr[%0d] got=%h want=%h", i, InstrD, 32'h13); end
      if (i == 1) begin
        total++; if (bus.imem_addr !== 32'h40) begin bad++; $display("FAIL rh_addr got=%h want=%h", bus.imem_addr, 32'h40); end
        total++; if (bus.imem_req !== 1'b1) begin bad++; $display("FAIL rh_req got=%b want=1", bus.imem_req); end
      end
      tick();
    end
    total++; if (InstrD !== 32'hA000_0040) begin bad++; $display("FAIL rh_instr got=%h want=%h", InstrD, 32'hA000_0040); end
    total++; if (PCD !== 32'h40) begin bad++; $display("FAIL rh_pcd got=%h want=%h", PCD, 32'h40); end
    total++; if (PCPlus4D !== 32'h44) begin bad++; $display("FAIL rh_pc4 got=%h want=%h", PCPlus4D, 32'h44); end
  endtask

  task automatic test_backpressure();
    bus.imem_ready = 1'b0;
    mem_lat = 3;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++; if (bus.imem_req !== 1'b1) begin bad++; $display("FAIL bp_req[%0d] got=%b want=1", i, bus.imem_req); end
      total++; if (bus.imem_addr !== 32'h44) begin bad++; $display("FAIL bp_addr[%0d] got=%h want=%h", i, bus.imem_addr, 32'h44); end
      total++; if (InstrD !== 32'h13) begin bad++; $display("FAIL bp_instr[%0d] got=%h want=%h", i, InstrD, 32'h13); end
      total++; if (PCD !== 32'h0) begin bad++; $display("FAIL bp_pcd[%0d] got=%h want=%h", i, PCD, 32'h0); end
    end
    bus.imem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (i == 0) mem_lat = 1;
      total++; if (InstrD !== 32'h13) begin bad++; $display("FAIL lat_instr[%0d] got=%h want=%h", i, InstrD, 32'h13); end
      total++; if (PCD !== 32'h0) begin bad++; $display("FAIL lat_pcd[%0d] got=%h want=%h", i, PCD, 32'h0); end
    end
    tick();
    total++; if (InstrD !== 32'hA000_0044) begin bad++; $display("FAIL lat_instr got=%h want=%h", InstrD, 32'hA000_0044); end
    total++; if (PCD !== 32'h44) begin bad++; $display("FAIL lat_pcd got=%h want=%h", PCD, 32'h44); end
  endtask

  task automatic test_wrap_and_reset();
    bus.imem_ready = 1'b0; PCSrcE = 1'b1; PCTargetE = 32'hFFFF_FFFC;
    tick();
    total++; if (bus.imem_addr !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_req_addr got=%h want=%h", bus.imem_addr, 32'hFFFF_FFFC); end
    bus.imem_ready = 1'b1; PCSrcE = 1'b0;
    tick();
    tick();
    total++; if (InstrD !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_instr got=%h want=%h", InstrD, 32'hFFFF_FFFC); end
    total++; if (PCD !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_pcd got=%h want=%h", PCD, 32'hFFFF_FFFC); end
    total++; if (PCPlus4D !== 32'h0) begin bad++; $display("FAIL wrap_pc4 got=%h want=%h", PCPlus4D, 32'h0); end
    total++; if (bus.imem_addr !== 32'h0) begin bad++; $display("FAIL wrap_addr got=%h want=%h", bus.imem_addr, 32'h0); end
    mem_lat = 3;
    tick();
    total++; if (bus.imem_req !== 1'b0) begin bad++; $display("FAIL midwait_req got=%b want=0", bus.imem_req); end
    rst = 1'b1;
    #1;
    total++; if (InstrD !== 32'h13) begin bad++; $display("FAIL arst_instr got=%h want=%h", InstrD, 32'h13); end
    total++; if (PCD !== 32'h0) begin bad++; $display("FAIL arst_pcd got=%h want=%h", PCD, 32'h0); end
    total++; if (bus.imem_req !== 1'b0) begin bad++; $display("FAIL arst_req got=%b want=0", bus.imem_req); end
    tick();
    rst = 1'b0;
    #1;
    total++; if (bus.imem_req !== 1'b1) begin bad++; $display("FAIL rerel_req got=%b want=1", bus.imem_req); end
    total++; if (bus.imem_addr !== 32'h0) begin bad++; $display("FAIL rerel_addr got=%h want=%h", bus.imem_addr, 32'h0); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_flush_redirect();
    test_redirect_handshake();
    test_backpressure();
    test_wrap_and_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
